// File: rtl/scanline_fx.sv
// scanline_fx: CRT scanline emulation on the scandoubled pixel stream.
// The colour path is two ce_pix stages deep. Syncs and blanks travel
// alongside the colour so all outputs stay aligned. Every other line is
// darkened by a strength that is latched at each vsync rising edge.
module scanline_fx #(
  parameter int HALF_DEPTH = 0,
  localparam int DW = (HALF_DEPTH != 0) ? 3 : 7
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [1:0]    scanlines,
  input  logic          phase,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  input  logic [DW:0]   r_in,
  input  logic [DW:0]   g_in,
  input  logic [DW:0]   b_in,
  output logic          ce_pix_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic [DW:0]   r_out,
  output logic [DW:0]   g_out,
  output logic [DW:0]   b_out
);

  // Line tracking and latched darkening mode
  logic       hs_prev_q, vs_prev_q;
  logic       line_odd_q;
  logic [1:0] mode_lat_q;

  // Stage 1 registers
  logic [DW:0] r1_q, g1_q, b1_q;
  logic        hs1_q, vs1_q, hb1_q, vb1_q;
  logic        dark_q, blank_q;

  // Per-channel shading. mode 0 with dark set only happens for pixels still
  // in flight across a vs edge (inside vblank), so it simply passes through.
  function automatic logic [DW:0] shade(input logic [DW:0] c, input logic dk,
                                        input logic bl, input logic [1:0] m);
    logic [DW:0] res;
    res = c;
    if (bl)
      res = '0;
    else if (dk) begin
      case (m)
        2'd1:    res = c - (c >> 2);
        2'd2:    res = c >> 1;
        2'd3:    res = c >> 2;
        default: res = c;
      endcase
    end
    return res;
  endfunction

  // Pixel-enable delay runs on every clock
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) ce_pix_out <= 1'b0;
    else       ce_pix_out <= ce_pix;
  end

  // Sync edge detection: vs edge resets line parity and latches the mode,
  // taking priority over a coincident hs toggle
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      line_odd_q <= 1'b0;
      mode_lat_q <= 2'd0;
    end else if (ce_pix) begin
      hs_prev_q <= hs_in;
      vs_prev_q <= vs_in;
      if (~vs_prev_q & vs_in) begin
        line_odd_q <= 1'b0;
        mode_lat_q <= scanlines;
      end else if (~hs_prev_q & hs_in) begin
        line_odd_q <= ~line_odd_q;
      end
    end
  end

  // Stage 1: capture pixel and decide darken/blank from pre-update line parity
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      hb1_q   <= 1'b0;
      vb1_q   <= 1'b0;
      dark_q  <= 1'b0;
      blank_q <= 1'b0;
    end else if (ce_pix) begin
      r1_q    <= r_in;
      g1_q    <= g_in;
      b1_q    <= b_in;
      hs1_q   <= hs_in;
      vs1_q   <= vs_in;
      hb1_q   <= hb_in;
      vb1_q   <= vb_in;
      dark_q  <= (mode_lat_q != 2'd0) & (line_odd_q == phase);
      blank_q <= hb_in | vb_in;
    end
  end

  // Stage 2: apply shading and forward syncs/blanks
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      hb_out <= 1'b0;
      vb_out <= 1'b0;
    end else if (ce_pix) begin
      r_out  <= shade(r1_q, dark_q, blank_q, mode_lat_q);
      g_out  <= shade(g1_q, dark_q, blank_q, mode_lat_q);
      b_out  <= shade(b1_q, dark_q, blank_q, mode_lat_q);
      hs_out <= hs1_q;
      vs_out <= vs1_q;
      hb_out <= hb1_q;
      vb_out <= vb1_q;
    end
  end

endmodule

// File: tb/tb_scanline_fx.sv
// Bench for scanline_fx: 8-bit and 4-bit instances share one stimulus stream.
// Each driven pixel pushes its stage-1 view into a queue; the entry is popped
// and scored when the DUT produces it one ce_pix later.
module tb_scanline_fx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [1:0] scan;
  logic       phase;
  logic       hs, vs, hb, vb;
  logic [7:0] r, g, b;

  logic       ce_o, hs_o, vs_o, hb_o, vb_o;
  logic [7:0] r_o, g_o, b_o;
  logic       h_ce, h_hs, h_vs, h_hb, h_vb;
  logic [3:0] hr_o, hg_o, hb4_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, hb, vb, dark, blank;
  } ent_t;
  ent_t q[$];

  // reference model state
  logic       m_lo, m_hsp, m_vsp;
  logic [1:0] m_mode;
  logic [7:0] last_r;
  logic       last_hb;

  always #5 clk = ~clk;

  scanline_fx #(.HALF_DEPTH(0)) dut (
    .clk_vid(clk), .reset(reset), .ce_pix(ce), .scanlines(scan), .phase(phase),
    .hs_in(hs), .vs_in(vs), .hb_in(hb), .vb_in(vb),
    .r_in(r), .g_in(g), .b_in(b),
    .ce_pix_out(ce_o), .hs_out(hs_o), .vs_out(vs_o), .hb_out(hb_o), .vb_out(vb_o),
    .r_out(r_o), .g_out(g_o), .b_out(b_o));

  scanline_fx #(.HALF_DEPTH(1)) dut_h (
    .clk_vid(clk), .reset(reset), .ce_pix(ce), .scanlines(scan), .phase(phase),
    .hs_in(hs), .vs_in(vs), .hb_in(hb), .vb_in(vb),
    .r_in(r[3:0]), .g_in(g[3:0]), .b_in(b[3:0]),
    .ce_pix_out(h_ce), .hs_out(h_hs), .vs_out(h_vs), .hb_out(h_hb), .vb_out(h_vb),
    .r_out(hr_o), .g_out(hg_o), .b_out(hb4_o));

  function automatic logic [7:0] fx8(input logic [7:0] c, input logic d, bl,
                                     input logic [1:0] m);
    if (bl) return 8'h00;
    if (!d) return c;
    case (m)
      2'd1: return c - (c >> 2);
      2'd2: return c >> 1;
      2'd3: return c >> 2;
      default: return c;
    endcase
  endfunction

  function automatic logic [3:0] fx4(input logic [3:0] c, input logic d, bl,
                                     input logic [1:0] m);
    if (bl) return 4'h0;
    if (!d) return c;
    case (m)
      2'd1: return c - (c >> 2);
      2'd2: return c >> 1;
      2'd3: return c >> 2;
      default: return c;
    endcase
  endfunction

  task automatic model_clear();
    q.delete();
    m_lo = 0; m_hsp = 0; m_vsp = 0; m_mode = 0;
    last_r = 0; last_hb = 0;
  endtask

  // Drive one ce_pix pixel, update the model, score the pixel leaving stage 2
  task automatic pix(input bit h, v, hbl, vbl, input logic [7:0] cr, cg, cb);
    ent_t e, o;
    logic [1:0] mb;
    logic [7:0] er, eg, eb;
    logic [3:0] hr, hg, hbv;
    @(negedge clk);
    ce = 1; hs = h; vs = v; hb = hbl; vb = vbl; r = cr; g = cg; b = cb;
    mb = m_mode;
    e.r = cr; e.g = cg; e.b = cb; e.hs = h; e.vs = v; e.hb = hbl; e.vb = vbl;
    e.dark = (m_mode != 0) && (m_lo == phase);
    e.blank = hbl | vbl;
    q.push_back(e);
    if (v && !m_vsp) begin m_lo = 0; m_mode = scan; end
    else if (h && !m_hsp) m_lo = !m_lo;
    m_hsp = h; m_vsp = v;
    @(posedge clk); #1;
    checks++;
    if (ce_o !== 1'b1) begin failures++; $display("FAIL ce_pix_out_on got=%b exp=1", ce_o); end
    if (q.size() == 2) begin
      o = q.pop_front();
      er = fx8(o.r, o.dark, o.blank, mb);
      eg = fx8(o.g, o.dark, o.blank, mb);
      eb = fx8(o.b, o.dark, o.blank, mb);
      hr = fx4(o.r[3:0], o.dark, o.blank, mb);
      hg = fx4(o.g[3:0], o.dark, o.blank, mb);
      hbv = fx4(o.b[3:0], o.dark, o.blank, mb);
      checks++;
      if ({r_o, g_o, b_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL rgb8 got=%h_%h_%h exp=%h_%h_%h", r_o, g_o, b_o, er, eg, eb);
      end
      checks++;
      if ({hs_o, vs_o, hb_o, vb_o} !== {o.hs, o.vs, o.hb, o.vb}) begin
        failures++;
        $display("FAIL syncs got=%b%b%b%b exp=%b%b%b%b", hs_o, vs_o, hb_o, vb_o,
                 o.hs, o.vs, o.hb, o.vb);
      end
      checks++;
      if ({hr_o, hg_o, hb4_o} !== {hr, hg, hbv}) begin
        failures++;
        $display("FAIL rgb4 got=%h_%h_%h exp=%h_%h_%h", hr_o, hg_o, hb4_o, hr, hg, hbv);
      end
      last_r = er; last_hb = o.hb;
    end
    ce = 0;
  endtask

  // Clock with ce_pix low: outputs must hold, ce_pix_out must drop
  task automatic idle();
    @(negedge clk);
    ce = 0;
    r = 8'($urandom); hs = 1'($urandom);
    @(posedge clk); #1;
    checks++;
    if (ce_o !== 1'b0 || r_o !== last_r || hb_o !== last_hb) begin
      failures++;
      $display("FAIL idle_hold got ce=%b r=%h hb=%b exp ce=0 r=%h hb=%b",
               ce_o, r_o, hb_o, last_r, last_hb);
    end
    hs = m_hsp;
  endtask

  task automatic vsync(input logic [7:0] c);
    pix(0, 1, 0, 1, c, c, c);
  endtask

  task automatic line(input bit with_hs, input logic [7:0] c);
    pix(with_hs, 0, 0, 0, c, c, c);
    repeat (3) pix(0, 0, 0, 0, c, c, c);
  endtask

  task automatic test_reset();
    reset = 1; ce = 0; scan = 0; phase = 0;
    hs = 0; vs = 0; hb = 0; vb = 0; r = 0; g = 0; b = 0;
    model_clear();
    #12;
    checks++;
    if ({ce_o, hs_o, vs_o, hb_o, vb_o, r_o, g_o, b_o, hr_o} !== '0) begin
      failures++; $display("FAIL reset_state got r=%h ce=%b exp all zero", r_o, ce_o);
    end
    @(negedge clk); reset = 0;
    repeat (4) pix(0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    // mid-frame async assert, checked before any further clock edge
    #3 reset = 1;
    #1;
    checks++;
    if ({ce_o, hs_o, vs_o, hb_o, vb_o, r_o, g_o, b_o, hr_o, hg_o, hb4_o} !== '0) begin
      failures++; $display("FAIL reset_async got r=%h g=%h ce=%b exp all zero", r_o, g_o, ce_o);
    end
    model_clear();
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic test_passthrough();
    scan = 0;
    pix(0, 0, 0, 0, 8'h12, 8'h34, 8'h56);
    pix(0, 0, 0, 0, 8'h9A, 8'hBC, 8'hDE);
    checks++;
    if ({r_o, g_o, b_o} !== 24'h123456) begin
      failures++; $display("FAIL passthrough got=%h exp=123456", {r_o, g_o, b_o});
    end
    repeat (6) pix(0, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_mode2_lines();
    scan = 2; phase = 0;
    vsync(8'hC8);
    line(0, 8'hC8);
    checks++;
    if (r_o !== 8'h64 || hr_o !== 4'h4) begin
      failures++; $display("FAIL mode2_line0 got=%h/%h exp=64/4", r_o, hr_o);
    end
    line(1, 8'hC8);
    checks++;
    if (r_o !== 8'hC8 || g_o !== 8'hC8) begin
      failures++; $display("FAIL mode2_line1 got=%h exp=c8", r_o);
    end
    line(1, 8'hC8);
    checks++;
    if (b_o !== 8'h64) begin
      failures++; $display("FAIL mode2_line2 got=%h exp=64", b_o);
    end
  endtask

  task automatic test_mode1_mode3();
    scan = 1; phase = 0;
    vsync(8'hFF);
    line(0, 8'hFF);
    checks++;
    if (r_o !== 8'hC0 || hr_o !== 4'hC) begin
      failures++; $display("FAIL mode1 got=%h/%h exp=c0/c", r_o, hr_o);
    end
    scan = 3;
    vsync(8'hFF);
    line(0, 8'hFF);
    checks++;
    if (r_o !== 8'h3F || hr_o !== 4'h3) begin
      failures++; $display("FAIL mode3 got=%h/%h exp=3f/3", r_o, hr_o);
    end
  endtask

  task automatic test_midframe();
    scan = 0; phase = 0;
    vsync(8'hA4);
    line(0, 8'hA4);
    scan = 3;
    line(1, 8'hA4);
    line(1, 8'hA4);
    checks++;
    if (r_o !== 8'hA4) begin
      failures++; $display("FAIL midframe_nochange got=%h exp=a4", r_o);
    end
    vsync(8'hA4);
    line(0, 8'hA4);
    checks++;
    if (r_o !== 8'h29) begin
      failures++; $display("FAIL midframe_after_vs got=%h exp=29", r_o);
    end
  endtask

  task automatic test_hs_vs_same();
    scan = 2; phase = 0;
    pix(1, 1, 0, 1, 8'hC8, 8'hC8, 8'hC8);
    line(0, 8'hC8);
    checks++;
    if (r_o !== 8'h64) begin
      failures++; $display("FAIL hs_vs_same got=%h exp=64", r_o);
    end
  endtask

  task automatic test_blank_ce();
    scan = 0;
    vsync(8'hFF);
    pix(0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    pix(0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (hb_o !== 1'b0 || r_o !== 8'hFF) begin
      failures++; $display("FAIL blank_before got hb=%b r=%h exp hb=0 r=ff", hb_o, r_o);
    end
    idle();
    pix(0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (hb_o !== 1'b1 || r_o !== 8'h00) begin
      failures++; $display("FAIL blank_after got hb=%b r=%h exp hb=1 r=00", hb_o, r_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) scan = 2'($urandom);
      if ($urandom_range(0, 15) == 0) phase = 1'($urandom);
      pix($urandom_range(0, 5) == 0, $urandom_range(0, 25) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
          8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mode2_lines();
    test_mode1_mode3();
    test_midframe();
    test_hs_vs_same();
    test_blank_ce();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
